// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO for any depth >= 2.
// Supports registered or first-word-fall-through reads, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. All status outputs come from registered state,
// so w_req/r_req never reach w_stall/r_stall combinationally.
module fifo_param #(
  parameter int COL_BIT_WIDTH  = 32,
  parameter int ROWS           = 8,
  parameter int FWFT           = 0,
  parameter int AF_THRESH      = ROWS - 1,
  parameter int AE_THRESH      = 1,
  localparam int ROW_ADDR_WIDTH = $clog2(ROWS),
  localparam int CNT_WIDTH      = $clog2(ROWS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      err_clr,
  input  logic                      w_req,
  input  logic [COL_BIT_WIDTH-1:0]  w_data,
  output logic                      w_stall,
  input  logic                      r_req,
  output logic [COL_BIT_WIDTH-1:0]  r_data,
  output logic                      r_stall,
  output logic [ROW_ADDR_WIDTH-1:0] write_ptr,
  output logic [ROW_ADDR_WIDTH-1:0] read_ptr,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROWS - 1);
  localparam logic [CNT_WIDTH-1:0]      FULL_CNT = CNT_WIDTH'(ROWS);

  logic [COL_BIT_WIDTH-1:0]  r_mem [ROWS];
  logic [ROW_ADDR_WIDTH-1:0] r_write_ptr;
  logic [ROW_ADDR_WIDTH-1:0] r_read_ptr;
  logic [CNT_WIDTH-1:0]      r_count;
  logic                      r_w_stall;
  logic                      r_r_stall;
  logic                      r_almost_full;
  logic                      r_almost_empty;
  logic                      r_overflow;
  logic                      r_underflow;

  logic [ROW_ADDR_WIDTH-1:0] w_write_ptr_nxt;
  logic [ROW_ADDR_WIDTH-1:0] w_read_ptr_nxt;
  logic [CNT_WIDTH-1:0]      w_count_nxt;
  logic                      w_wacc;
  logic                      w_racc;
  logic                      w_ovf_evt;
  logic                      w_unf_evt;

  // Wrap a row pointer at ROWS-1 so non-power-of-two depths work.
  function automatic logic [ROW_ADDR_WIDTH-1:0] ptr_inc(input logic [ROW_ADDR_WIDTH-1:0] p);
    if (p == LAST_ROW) begin
      return {ROW_ADDR_WIDTH{1'b0}};
    end else begin
      return p + ROW_ADDR_WIDTH'(1);
    end
  endfunction

  // Accept/error decode and next-state for pointers and occupancy.
  always_comb begin
    w_wacc          = w_req & ~r_w_stall & ~flush;
    w_racc          = r_req & ~r_r_stall & ~flush;
    w_ovf_evt       = w_req &  r_w_stall & ~flush;
    w_unf_evt       = r_req &  r_r_stall & ~flush;
    w_write_ptr_nxt = r_write_ptr;
    w_read_ptr_nxt  = r_read_ptr;
    w_count_nxt     = r_count;
    if (flush) begin
      w_write_ptr_nxt = {ROW_ADDR_WIDTH{1'b0}};
      w_read_ptr_nxt  = {ROW_ADDR_WIDTH{1'b0}};
      w_count_nxt     = {CNT_WIDTH{1'b0}};
    end else begin
      if (w_wacc) begin
        w_write_ptr_nxt = ptr_inc(r_write_ptr);
      end else begin
        w_write_ptr_nxt = r_write_ptr;
      end
      if (w_racc) begin
        w_read_ptr_nxt = ptr_inc(r_read_ptr);
      end else begin
        w_read_ptr_nxt = r_read_ptr;
      end
      case ({w_wacc, w_racc})
        2'b10:   w_count_nxt = r_count + CNT_WIDTH'(1);
        2'b01:   w_count_nxt = r_count - CNT_WIDTH'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer, count, status flag and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_ptr    <= {ROW_ADDR_WIDTH{1'b0}};
      r_read_ptr     <= {ROW_ADDR_WIDTH{1'b0}};
      r_count        <= {CNT_WIDTH{1'b0}};
      r_w_stall      <= 1'b0;
      r_r_stall      <= 1'b1;
      r_almost_full  <= (AF_THRESH <= 0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_write_ptr    <= w_write_ptr_nxt;
      r_read_ptr     <= w_read_ptr_nxt;
      r_count        <= w_count_nxt;
      r_w_stall      <= (w_count_nxt == FULL_CNT);
      r_r_stall      <= (w_count_nxt == {CNT_WIDTH{1'b0}});
      r_almost_full  <= (int'(w_count_nxt) >= AF_THRESH);
      r_almost_empty <= (int'(w_count_nxt) <= AE_THRESH);
      // A new error event in the same cycle as err_clr keeps the flag set.
      r_overflow     <= w_ovf_evt | (r_overflow  & ~err_clr);
      r_underflow    <= w_unf_evt | (r_underflow & ~err_clr);
    end
  end

  // Storage array; contents survive reset and flush by design.
  always_ff @(posedge clk) begin
    if (!reset && w_wacc) begin
      r_mem[r_write_ptr] <= w_data;
    end
  end

  if (FWFT != 0) begin : g_fwft
    logic [COL_BIT_WIDTH-1:0] w_r_data;

    // Head word is presented directly; zero while empty.
    always_comb begin
      if (r_r_stall) begin
        w_r_data = {COL_BIT_WIDTH{1'b0}};
      end else begin
        w_r_data = r_mem[r_read_ptr];
      end
    end

    assign r_data = w_r_data;
  end else begin : g_regrd
    logic [COL_BIT_WIDTH-1:0] r_rdata;

    // Registered read: capture the head word on an accepted pop, else hold.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_rdata <= {COL_BIT_WIDTH{1'b0}};
      end else if (w_racc) begin
        r_rdata <= r_mem[r_read_ptr];
      end else begin
        r_rdata <= r_rdata;
      end
    end

    assign r_data = r_rdata;
  end

  assign w_stall      = r_w_stall;
  assign r_stall      = r_r_stall;
  assign write_ptr    = r_write_ptr;
  assign read_ptr     = r_read_ptr;
  assign count        = r_count;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: self-checking bench for fifo_param.
// Instance A: ROWS=5, FWFT=1 (wrap, overflow, reset mid-stream).
// Instance B: ROWS=8, FWFT=0, AF=6, AE=2 (vector table with read scoreboard).
module tb_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance A signals ----------------
  logic        a_reset, a_flush, a_err_clr, a_w_req, a_r_req;
  logic [31:0] a_w_data, a_r_data;
  logic        a_w_stall, a_r_stall, a_af, a_ae, a_ovf, a_unf;
  logic [2:0]  a_wp, a_rp;
  logic [2:0]  a_count;

  // ---------------- instance B signals ----------------
  logic        b_reset, b_flush, b_err_clr, b_w_req, b_r_req;
  logic [31:0] b_w_data, b_r_data;
  logic        b_w_stall, b_r_stall, b_af, b_ae, b_ovf, b_unf;
  logic [2:0]  b_wp, b_rp;
  logic [3:0]  b_count;

  fifo_param #(.COL_BIT_WIDTH(32), .ROWS(5), .FWFT(1)) dut_a (
    .clk(clk), .reset(a_reset), .flush(a_flush), .err_clr(a_err_clr),
    .w_req(a_w_req), .w_data(a_w_data), .w_stall(a_w_stall),
    .r_req(a_r_req), .r_data(a_r_data), .r_stall(a_r_stall),
    .write_ptr(a_wp), .read_ptr(a_rp), .count(a_count),
    .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_param #(.COL_BIT_WIDTH(32), .ROWS(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush), .err_clr(b_err_clr),
    .w_req(b_w_req), .w_data(b_w_data), .w_stall(b_w_stall),
    .r_req(b_r_req), .r_data(b_r_data), .r_stall(b_r_stall),
    .write_ptr(b_wp), .read_ptr(b_rp), .count(b_count),
    .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table for instance B ----------------
  typedef struct {
    logic        wr, rd, fl, ec;
    logic [31:0] d;
    logic [3:0]  cnt;
    logic [2:0]  wp, rp;
    logic        wst, rst, af, ae, ovf, unf;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic wr, rd, fl, ec, input logic [31:0] d,
                     input logic [3:0] cnt, input logic [2:0] wp, rp,
                     input logic wst, rst, af, ae, ovf, unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.ec = ec; v.d = d;
    v.cnt = cnt; v.wp = wp; v.rp = rp;
    v.wst = wst; v.rst = rst; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    vt.push_back(v);
  endtask

  // Scoreboards: B holds stored words and the expected registered r_data,
  // A holds the stored words for FWFT head comparison.
  logic [31:0] bq[$];
  logic [31:0] b_exp_rdata = 32'h0;
  logic [31:0] aq[$];

  // One cycle on instance A; pops are checked against the head before the edge.
  task automatic a_step(input logic rst, input logic wr, input logic rd, input logic [31:0] d);
    @(negedge clk);
    if (rd && !rst && aq.size() > 0) chk("a pop data", a_r_data, aq.pop_front());
    else if (rd && !rst && aq.size() == 0) begin end
    if (rst) aq.delete();
    else if (wr && aq.size() < 5) aq.push_back(d);
    a_reset = rst; a_w_req = wr; a_r_req = rd; a_w_data = d;
    @(posedge clk);
    #1;
    a_reset = 1'b0; a_w_req = 1'b0; a_r_req = 1'b0;
  endtask

  task automatic a_chk_reset(input string tag);
    chk({tag, " r_data"}, a_r_data, 32'h0);
    chk({tag, " wp"}, 32'(a_wp), 32'h0);
    chk({tag, " rp"}, 32'(a_rp), 32'h0);
    chk({tag, " count"}, 32'(a_count), 32'h0);
    chk({tag, " w_stall"}, 32'(a_w_stall), 32'h0);
    chk({tag, " r_stall"}, 32'(a_r_stall), 32'h1);
    chk({tag, " af"}, 32'(a_af), 32'h0);
    chk({tag, " ae"}, 32'(a_ae), 32'h1);
    chk({tag, " ovf"}, 32'(a_ovf), 32'h0);
    chk({tag, " unf"}, 32'(a_unf), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    a_reset = 1'b1; a_flush = 1'b0; a_err_clr = 1'b0; a_w_req = 1'b0; a_r_req = 1'b0; a_w_data = 32'h0;
    b_reset = 1'b1; b_flush = 1'b0; b_err_clr = 1'b0; b_w_req = 1'b0; b_r_req = 1'b0; b_w_data = 32'h0;

    //   wr    rd    fl    ec    data    cnt   wp    rp   wst   rst   af    ae    ovf   unf
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0a, 4'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 4'd2, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 4'd1, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 4'd0, 3'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h21, 4'd1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 4'd2, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h23, 4'd3, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 4'd4, 3'd6, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h25, 4'd5, 3'd7, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h26, 4'd6, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h27, 4'd7, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h28, 4'd8, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h29, 4'd7, 3'd2, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 4'd6, 3'd2, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h31, 4'd7, 3'd3, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h32, 4'd8, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'h33, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h41, 4'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'h51, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    a_chk_reset("a reset");
    chk("b reset r_data", b_r_data, 32'h0);
    chk("b reset r_stall", 32'(b_r_stall), 32'h1);
    chk("b reset af", 32'(b_af), 32'h0);
    chk("b reset ae", 32'(b_ae), 32'h1);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // ---------------- instance B: table-driven ----------------
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      b_w_req = vt[i].wr; b_r_req = vt[i].rd; b_flush = vt[i].fl;
      b_err_clr = vt[i].ec; b_w_data = vt[i].d;
      if (vt[i].fl) begin
        bq.delete();
      end else begin
        automatic bit racc = vt[i].rd && (bq.size() > 0);
        automatic bit wacc = vt[i].wr && (bq.size() < 8);
        if (racc) b_exp_rdata = bq.pop_front();
        if (wacc) bq.push_back(vt[i].d);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d r_data", i), b_r_data, b_exp_rdata);
      chk($sformatf("v%0d count", i), 32'(b_count), 32'(vt[i].cnt));
      chk($sformatf("v%0d wp", i), 32'(b_wp), 32'(vt[i].wp));
      chk($sformatf("v%0d rp", i), 32'(b_rp), 32'(vt[i].rp));
      chk($sformatf("v%0d w_stall", i), 32'(b_w_stall), 32'(vt[i].wst));
      chk($sformatf("v%0d r_stall", i), 32'(b_r_stall), 32'(vt[i].rst));
      chk($sformatf("v%0d af", i), 32'(b_af), 32'(vt[i].af));
      chk($sformatf("v%0d ae", i), 32'(b_ae), 32'(vt[i].ae));
      chk($sformatf("v%0d ovf", i), 32'(b_ovf), 32'(vt[i].ovf));
      chk($sformatf("v%0d unf", i), 32'(b_unf), 32'(vt[i].unf));
    end
    @(negedge clk);
    b_w_req = 1'b0; b_r_req = 1'b0; b_flush = 1'b0; b_err_clr = 1'b0;

    // ---------------- instance A: non-power-of-two wrap ----------------
    a_step(1'b0, 1'b1, 1'b0, 32'd14);
    chk("a fwft first word", a_r_data, 32'd14);
    chk("a fwft r_stall", 32'(a_r_stall), 32'h0);
    a_step(1'b0, 1'b1, 1'b0, 32'd18);
    a_step(1'b0, 1'b1, 1'b0, 32'd16);
    a_step(1'b0, 1'b1, 1'b0, 32'd20);
    a_step(1'b0, 1'b1, 1'b0, 32'd21);
    chk("a full w_stall", 32'(a_w_stall), 32'h1);
    chk("a full count", 32'(a_count), 32'd5);
    chk("a wp wrap", 32'(a_wp), 32'h0);
    chk("a ovf before", 32'(a_ovf), 32'h0);
    a_step(1'b0, 1'b1, 1'b0, 32'd22);
    chk("a ovf set", 32'(a_ovf), 32'h1);
    chk("a count after drop", 32'(a_count), 32'd5);
    for (int k = 0; k < 4; k++) a_step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("a rp before wrap", 32'(a_rp), 32'd4);
    a_step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("a rp wrap", 32'(a_rp), 32'h0);
    chk("a empty r_stall", 32'(a_r_stall), 32'h1);
    chk("a empty r_data", a_r_data, 32'h0);
    a_step(1'b0, 1'b1, 1'b0, 32'd9);
    chk("a wp after 9", 32'(a_wp), 32'd1);
    chk("a r_data 9", a_r_data, 32'd9);

    // ---------------- instance A: reset mid-stream ----------------
    a_step(1'b0, 1'b1, 1'b0, 32'd30);
    a_step(1'b0, 1'b1, 1'b0, 32'd31);
    chk("a count 3", 32'(a_count), 32'd3);
    a_step(1'b1, 1'b1, 1'b0, 32'd77);
    a_chk_reset("a mid reset");
    a_step(1'b0, 1'b1, 1'b0, 32'd25);
    chk("a post reset data", a_r_data, 32'd25);
    a_step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("a post pop r_stall", 32'(a_r_stall), 32'h1);
    chk("a post pop count", 32'(a_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
